// File: rtl/arbitro_pkg.sv
// Shared types and sizes for the round-robin arbiter/selector.
// Holds the FSM state enum and the requester/select widths.
package arbitro_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/arbitro_rr_mux_selector_rr.sv
// Combinational round-robin winner pick.
// Ports: i_Req (requests), i_Ptr (search start), o_Found, o_Idx (winner).
module selector_rr
  import arbitro_pkg::*;
(
  input  logic [N_REQ-1:0] i_Req,
  input  logic [SEL_W-1:0] i_Ptr,
  output logic             o_Found,
  output logic [SEL_W-1:0] o_Idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down so the nearest
  // request to i_Ptr is the last (winning) assignment.
  always_comb begin
    o_Found = 1'b0;
    o_Idx   = i_Ptr;
    cand    = i_Ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = i_Ptr + SEL_W'(i);
      if (i_Req[cand]) begin
        o_Found = 1'b1;
        o_Idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_mux.sv
// Round-robin arbiter + 4:1 selector with registered output and valid.
// Ports: i_Clk, i_Reset (async high), i_Req[3:0], i_Datos_0..3 in;
//   o_Gnt (one-hot), o_Sel, o_Salida, o_Valido out.
// Macro ARB_BURST_LIMIT_EN: caps each grant at BURST_MAX cycles.
module arbitro_rr_mux
  import arbitro_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int BURST_MAX = 4
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [N_REQ-1:0] i_Req,
  input  logic [WIDTH-1:0] i_Datos_0,
  input  logic [WIDTH-1:0] i_Datos_1,
  input  logic [WIDTH-1:0] i_Datos_2,
  input  logic [WIDTH-1:0] i_Datos_3,
  output logic [N_REQ-1:0] o_Gnt,
  output logic [SEL_W-1:0] o_Sel,
  output logic [WIDTH-1:0] o_Salida,
  output logic             o_Valido
);

  if (BURST_MAX < 1) begin : g_bad_burst
    $error("BURST_MAX must be at least 1");
  end

  state_t           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [N_REQ-1:0] gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] sal_q;
  logic             val_q;

  logic [SEL_W-1:0] srch_ptr;
  logic [SEL_W-1:0] win_idx;
  logic             win_found;
  logic [WIDTH-1:0] dat_sel;
  logic             req_own;
  logic             leave;

  // In TURN the pointer is advanced on the same edge that
  // picks the next owner, so search from owner+1 directly.
  assign srch_ptr = (state_q == TURN) ? sel_q + SEL_W'(1) : ptr_q;

  selector_rr u_sel (
    .i_Req   (i_Req),
    .i_Ptr   (srch_ptr),
    .o_Found (win_found),
    .o_Idx   (win_idx)
  );

  always_comb begin
    unique case (sel_q)
      2'd0: dat_sel = i_Datos_0;
      2'd1: dat_sel = i_Datos_1;
      2'd2: dat_sel = i_Datos_2;
      2'd3: dat_sel = i_Datos_3;
    endcase
  end

  assign req_own = i_Req[sel_q];

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating count of granted cycles with the owner requesting.
  assign cnt_d = (cnt_q == CNT_W'(BURST_MAX)) ? cnt_q
                                             : cnt_q + CNT_W'(1);
  // The limit edge ends the grant instead of transferring a word.
  assign leave = !req_own || (cnt_d == CNT_W'(BURST_MAX));
`else
  assign leave = !req_own;
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      sal_q   <= '0;
      val_q   <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE, TURN: begin
          if (state_q == TURN) ptr_q <= srch_ptr;
          if (win_found) begin
            state_q <= GRANT;
            gnt_q   <= N_REQ'(1) << win_idx;
            sel_q   <= win_idx;
`ifdef ARB_BURST_LIMIT_EN
            cnt_q   <= '0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (leave) begin
            state_q <= TURN;
            gnt_q   <= '0;
            val_q   <= 1'b0;
          end else begin
            sal_q   <= dat_sel;
            val_q   <= 1'b1;
`ifdef ARB_BURST_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Gnt    = gnt_q;
  assign o_Sel    = sel_q;
  assign o_Salida = sal_q;
  assign o_Valido = val_q;

endmodule

// File: tb/tb_arbitro_rr_mux.sv
// Self-checking bench for arbitro_rr_mux.
// Owner-level reference model plus literal directed checks.
module tb_arbitro_rr_mux;

  localparam int BM = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] sal;
  logic       val;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  arbitro_rr_mux #(.WIDTH(4), .BURST_MAX(BM)) dut (
    .i_Clk     (clk),
    .i_Reset   (rst),
    .i_Req     (req),
    .i_Datos_0 (d0),
    .i_Datos_1 (d1),
    .i_Datos_2 (d2),
    .i_Datos_3 (d3),
    .o_Gnt     (gnt),
    .o_Sel     (sel),
    .o_Salida  (sal),
    .o_Valido  (val)
  );

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference model: who owns the output, whether we sit in the
  // dead cycle after a grant, and how long the owner has held it.
  int         m_owner = -1;
  bit         m_dead  = 1'b0;
  int         m_ptr   = 0;
  int         m_runs  = 0;
  logic [3:0] e_gnt   = '0;
  int         e_sel   = 0;
  logic [3:0] e_sal   = '0;
  logic       e_val   = 1'b0;

  function automatic int pick(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] word(int k);
    case (k)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  task automatic grant_to(int w);
    if (w >= 0) begin
      m_owner = w;
      e_sel   = w;
      e_gnt   = 4'b0001 << w;
      m_runs  = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_dead = 1'b0; m_ptr = 0; m_runs = 0;
      e_gnt = '0; e_sel = 0; e_sal = '0; e_val = 1'b0;
    end else if (m_dead) begin
      m_dead = 1'b0;
      m_ptr  = (e_sel + 1) % 4;
      grant_to(pick(req, m_ptr));
    end else if (m_owner < 0) begin
      grant_to(pick(req, m_ptr));
    end else if (req[m_owner] && !(BURST_ON && m_runs + 1 >= BM)) begin
      m_runs = m_runs + 1;
      e_sal  = word(m_owner);
      e_val  = 1'b1;
    end else begin
      m_owner = -1;
      m_dead  = 1'b1;
      e_gnt   = '0;
      e_val   = 1'b0;
    end
  end

  logic [1:0] e_sel2;
  assign e_sel2 = e_sel[1:0];

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_gnt", 8'(gnt), 8'(e_gnt));
      chk("cyc_sel", 8'(sel), 8'(e_sel2));
      chk("cyc_sal", 8'(sal), 8'(e_sal));
      chk("cyc_val", 8'(val), 8'(e_val));
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  logic [3:0] gh [1:24];
  logic [3:0] sh [1:24];
  logic       vh [1:24];
  logic [3:0] pat [20];

  initial begin
    rst = 1'b1;
    req = '0;
    d0 = 4'b0100; d1 = 4'b1000; d2 = 4'b1100; d3 = 4'b1111;
    tick(2);
    rst = 1'b0;
    #1;
    chk("rst_gnt", 8'(gnt), 8'h00);
    chk("rst_sel", 8'(sel), 8'h00);
    chk("rst_sal", 8'(sal), 8'h00);
    chk("rst_val", 8'(val), 8'h00);

    // Single requester latency
    req = 4'b0001;
    tick(1);
    chk("lat_gnt", 8'(gnt), 8'b0001);
    chk("lat_sel", 8'(sel), 8'h00);
    tick(1);
    chk("lat_sal", 8'(sal), 8'b0100);
    chk("lat_val", 8'(val), 8'h01);

    // All four requesting continuously
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      gh[k] = gnt; sh[k] = sal; vh[k] = val;
    end
`ifdef ARB_BURST_LIMIT_EN
    chk("all_g4",  8'(gh[4]),  8'b0001);
    chk("all_g5",  8'(gh[5]),  8'b0000);
    chk("all_g6",  8'(gh[6]),  8'b0010);
    chk("all_g9",  8'(gh[9]),  8'b0010);
    chk("all_g10", 8'(gh[10]), 8'b0000);
    chk("all_g11", 8'(gh[11]), 8'b0100);
    chk("all_g16", 8'(gh[16]), 8'b1000);
    chk("all_g20", 8'(gh[20]), 8'b0000);
    chk("all_g21", 8'(gh[21]), 8'b0001);
    chk("all_s4",  8'(sh[4]),  8'b0100);
    chk("all_s7",  8'(sh[7]),  8'b1000);
    chk("all_s12", 8'(sh[12]), 8'b1100);
    chk("all_s17", 8'(sh[17]), 8'b1111);
    chk("all_v5",  8'(vh[5]),  8'h00);
`else
    chk("all_g5",  8'(gh[5]),  8'b0001);
    chk("all_g10", 8'(gh[10]), 8'b0001);
    chk("all_g21", 8'(gh[21]), 8'b0001);
    chk("all_s21", 8'(sh[21]), 8'b0100);
    chk("all_v21", 8'(vh[21]), 8'h01);
`endif

    // Owner 2 drops while 3 waits
    do_reset();
    req = 4'b0100;
    tick(1);
    chk("drop_g0", 8'(gnt), 8'b0100);
    tick(1);
    req = 4'b1100;
    tick(1);
    req = 4'b1000;
    tick(1);
    chk("drop_turn_g", 8'(gnt), 8'b0000);
    chk("drop_turn_v", 8'(val), 8'h00);
    tick(1);
    chk("drop_next_g", 8'(gnt), 8'b1000);
    chk("drop_next_s", 8'(sel), 8'b11);

    // Asynchronous reset while owner 1 holds the grant
    do_reset();
    req = 4'b0010;
    tick(2);
    chk("mid_pre_v", 8'(val), 8'h01);
    chk("mid_pre_s", 8'(sal), 8'b1000);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_g", 8'(gnt), 8'h00);
    chk("mid_rst_v", 8'(val), 8'h00);
    chk("mid_rst_s", 8'(sel), 8'h00);
    chk("mid_rst_d", 8'(sal), 8'h00);
    req = 4'b0110;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("mid_win_g", 8'(gnt), 8'b0010);
    chk("mid_win_s", 8'(sel), 8'b01);

    // Lone requester 3, repeated
    do_reset();
    req = 4'b1000;
    tick(5);
`ifdef ARB_BURST_LIMIT_EN
    chk("r3_turn", 8'(gnt), 8'b0000);
`else
    chk("r3_hold", 8'(gnt), 8'b1000);
`endif
    tick(1);
    chk("r3_again", 8'(gnt), 8'b1000);
    tick(12);

    // Mixed directed patterns, checked by the model only
    pat = '{4'b0110, 4'b0110, 4'b0110, 4'b0011, 4'b0000,
            4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
            4'b1001, 4'b0101, 4'b0000, 4'b0000, 4'b1111,
            4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0010};
    d0 = 4'b0011; d1 = 4'b0101; d2 = 4'b1010; d3 = 4'b0110;
    for (int i = 0; i < 20; i++) begin
      req = pat[i];
      tick(1);
    end
    req = '0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
